// File: rtl/bcd_sequential_converter.sv
// -----------------------------------------------------------------------------
// bcd_sequential_converter
//
// Sequential double-dabble converter: turns a 16-bit unsigned binary value into
// five BCD digits, one correct-and-shift iteration per clock. A one-cycle
// `start` pulse in IDLE captures `binary`. The result appears 17 edges later
// on D0..D4, accompanied by a one-cycle `valid` pulse. Digits hold their last
// converted value between conversions.
//
// Ports
//   clk     in   block clock (divided slow clock at the top level)
//   rst     in   synchronous, active-low reset
//   start   in   conversion request, only honoured in IDLE
//   binary  in   16-bit unsigned value, captured on the accepting edge
//   D0..D4  out  BCD digits {1'b0, bcd}; D0 is units, D4 is ten-thousands
//   busy    out  high while a conversion is in progress (state != IDLE)
//   valid   out  one-cycle pulse on the cycle D0..D4 take new values
// -----------------------------------------------------------------------------
module bcd_sequential_converter #(
   // Only 16 is supported: the 4-bit iteration counter covers exactly 16 shifts.
   parameter int BIN_W  = 16,
   // Five digits cover 0..65535; the five output ports assume this value.
   parameter int DIGITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] binary,
   output logic [4:0]       D0,
   output logic [4:0]       D1,
   output logic [4:0]       D2,
   output logic [4:0]       D3,
   output logic [4:0]       D4,
   output logic             busy,
   output logic             valid
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SCR_W = BCD_W + BIN_W;

   // Counter value during the final (16th) iteration.
   localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   logic [SCR_W-1:0] scratch_reg;   // {bcd, bin}
   logic [3:0]       count_reg;
   logic [3:0]       digit_reg [DIGITS];

   logic [SCR_W-1:0] corrected;
   logic [SCR_W-1:0] shifted;
   logic             unused_msb;

   // --------------------------------------------------------------------------
   // Add-3 correction: every BCD nibble that is >= 5 gets +3 before the shift,
   // so that the shift carries into the next decade correctly. All nibbles
   // are corrected in parallel; the binary part passes through untouched.
   // --------------------------------------------------------------------------
   assign corrected[BIN_W-1:0] = scratch_reg[BIN_W-1:0];

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_correct
         logic [3:0] nibble;
         assign nibble = scratch_reg[BIN_W + 4*gi +: 4];
         assign corrected[BIN_W + 4*gi +: 4] =
            (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
      end
   endgenerate

   // The bit shifted out of the top is always zero for legal 16-bit inputs
   // (the ten-thousands digit never exceeds 6), so it is simply dropped.
   assign shifted    = {corrected[SCR_W-2:0], 1'b0};
   assign unused_msb = corrected[SCR_W-1];

   // --------------------------------------------------------------------------
   // Control FSM and datapath registers. Reset wins over everything, including
   // a conversion in progress, which is aborted without a valid pulse.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         scratch_reg <= '0;
         count_reg   <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            digit_reg[i] <= 4'd0;
         end
      end else begin
         valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  scratch_reg <= {{BCD_W{1'b0}}, binary};
                  count_reg   <= 4'd0;
                  state_reg   <= SHIFT;
                  busy        <= 1'b1;
               end
            end

            SHIFT: begin
               scratch_reg <= shifted;
               count_reg   <= count_reg + 4'd1;
               if (count_reg == LAST_ITER) begin
                  state_reg <= DONE;
               end
            end

            DONE: begin
               // Digits only ever change here, on the DONE->IDLE edge.
               for (int i = 0; i < DIGITS; i++) begin
                  digit_reg[i] <= scratch_reg[BIN_W + 4*i +: 4];
               end
               valid     <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Output digits are straight from registers, padded to the 5-bit format.
   assign D0 = {1'b0, digit_reg[0]};
   assign D1 = {1'b0, digit_reg[1]};
   assign D2 = {1'b0, digit_reg[2]};
   assign D3 = {1'b0, digit_reg[3]};
   assign D4 = {1'b0, digit_reg[4]};

endmodule

// File: tb/tb_bcd_sequential_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_sequential_converter
//
// Scoreboard bench for bcd_sequential_converter. The stimulus process decides,
// from the converter's documented timing (accept in IDLE, 18-edge spacing,
// reset aborts), whether each start is accepted and pushes the expected
// decimal digits with their due edge. The monitor checks busy, valid and the
// held digits on every falling edge and pops an entry whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_bcd_sequential_converter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] binary = 16'd0;
   logic [4:0]  D0, D1, D2, D3, D4;
   logic        busy, valid;

   bcd_sequential_converter #(.BIN_W(16), .DIGITS(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .binary (binary),
      .D0     (D0),
      .D1     (D1),
      .D2     (D2),
      .D3     (D3),
      .D4     (D4),
      .busy   (busy),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   // Edge counter: after rising edge k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int value;
      int due;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Model state written by the stimulus process only.
   int acc_edge  = -1000;   // edge of the last accepted (non-aborted) start
   int next_ok   = 0;       // first edge at which a new start can be accepted
   int rst_count = 0;
   bit done      = 1'b0;

   // Decimal digits of v packed as five nibbles, units in [3:0].
   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d required %0d", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge sample them, then update the model.
   task automatic drive(input logic s, input logic [15:0] b, input logic r);
      int e;
      start  = s;
      binary = b;
      rst    = r;
      e      = cyc + 1;
      @(posedge clk);
      if (!r) begin
         sb.delete();
         rst_count++;
         acc_edge = -1000;
         next_ok  = e + 1;
      end else if (s && e >= next_ok) begin
         sb.push_back('{value: int'(b), due: e + 17});
         $display("start accepted: binary=%0d at edge %0d, expect %05d at edge %0d",
                  b, e, b, e + 17);
         acc_edge = e;
         next_ok  = e + 18;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 1'b1);
   endtask

   task automatic conv(input logic [15:0] v);
      drive(1'b1, v, 1'b1);
      idle(18);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int known [4] = '{0, 16129, 65535, 12345};

      // Reset held for two edges.
      drive(1'b0, 16'd0, 1'b0);
      drive(1'b0, 16'd0, 1'b0);
      idle(3);

      // Known values.
      foreach (known[i]) conv(16'(known[i]));

      // start while busy: extra starts at E5 and E16 must be ignored.
      drive(1'b1, 16'd100, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         if (k == 5 || k == 16) drive(1'b1, 16'd999, 1'b1);
         else                   drive(1'b0, 16'd999, 1'b1);
      end

      // Input change mid-conversion.
      drive(1'b1, 16'd4096, 1'b1);
      for (int k = 1; k <= 19; k++) drive(1'b0, (k >= 3) ? 16'd7 : 16'd4096, 1'b1);

      // Reset mid-conversion, then a fresh conversion.
      conv(16'd255);
      drive(1'b1, 16'd9999, 1'b1);
      idle(7);
      drive(1'b0, 16'd9999, 1'b0);
      idle(3);
      conv(16'd42);

      // Back-to-back: second start sampled on the edge after valid.
      drive(1'b1, 16'd1, 1'b1);
      idle(17);
      drive(1'b1, 16'd54321, 1'b1);
      idle(20);

      // Random traffic with occasional resets.
      for (int k = 0; k < 600; k++) begin
         drive(($urandom_range(0, 3) == 0), 16'($urandom),
               ($urandom_range(0, 249) != 0));
      end
      idle(20);

      done = 1'b1;
   end

   // ----------------------------------------------------------------- monitor
   initial begin
      logic [19:0] held;
      int          seen_rst;
      exp_t        e;

      held     = '0;
      seen_rst = 0;
      wait (cyc >= 1);
      while (!done) begin
         @(negedge clk);
         if (rst_count != seen_rst) begin
            held     = '0;
            seen_rst = rst_count;
         end

         chk("busy", 32'(busy), 32'((cyc >= acc_edge) && (cyc < acc_edge + 17)));

         if (valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("valid_unexpected", 32'(valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("valid_edge", 32'(cyc), 32'(e.due));
               held = to_bcd(e.value);
               $display("result: edge %0d digits %0d%0d%0d%0d%0d model %05d",
                        cyc, D4, D3, D2, D1, D0, e.value);
            end
         end else begin
            chk("valid_low", 32'(valid), 32'd0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               chk("valid_due", 32'(valid), 32'd1);
               void'(sb.pop_front());
            end
         end

         chk("D0", 32'(D0), 32'({1'b0, held[3:0]}));
         chk("D1", 32'(D1), 32'({1'b0, held[7:4]}));
         chk("D2", 32'(D2), 32'({1'b0, held[11:8]}));
         chk("D3", 32'(D3), 32'({1'b0, held[15:12]}));
         chk("D4", 32'(D4), 32'({1'b0, held[19:16]}));
      end

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
